// File: rtl/dsc_mul_pkg.sv
// Shared constants for the deterministic unary (stochastic) multiplier.
// The default operand width and the sizes derived from it live here.
package dsc_mul_pkg;

  localparam int WIDTH      = 4;
  localparam int OUT_W      = 3 * WIDTH;
  localparam int NUM_CYCLES = 2 ** OUT_W;

  // Accumulator width for a given operand width; it holds (2^w - 1)^3 exactly.
  function automatic int out_w(input int w);
    return 3 * w;
  endfunction

endpackage

// File: rtl/counter.sv
// Free-running WIDTH-bit counter that advances only when enabled.
// The overflow strobe marks the enabled cycle on which it wraps.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign out      = r_cnt;
  assign overflow = en & (r_cnt == '1);

endmodule

// File: rtl/dsc_mul.sv
// Exact three-operand multiplier using deterministic unary streams: z counts
// the points of the (cnt_a, cnt_b, cnt_c) cube lying below (a, b, c).
module dsc_mul
  import dsc_mul_pkg::*;
#(
  parameter int WIDTH = dsc_mul_pkg::WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [WIDTH-1:0]          c,
  output logic [out_w(WIDTH)-1:0]   z,
  output logic                      ov
);

  localparam int ZW = out_w(WIDTH);

  logic [WIDTH-1:0] w_cnt_a, w_cnt_b, w_cnt_c;
  logic             w_ovf_a, w_ovf_b, w_ovf_c;
  logic             w_en_int, w_en_b, w_en_c;
  logic             w_sa, w_sb, w_sc, w_p;
  logic [ZW-1:0]    r_z;
  logic             r_ov;

  // Once finished, the enable is cut so the whole datapath freezes until reset.
  assign w_en_int = en & ~r_ov;
  assign w_en_b   = w_en_int & w_ovf_a;
  assign w_en_c   = w_en_int & w_ovf_b;

  counter #(.WIDTH(WIDTH)) u_cnt_a (
    .clk(clk), .rst(rst), .en(w_en_int), .out(w_cnt_a), .overflow(w_ovf_a)
  );
  counter #(.WIDTH(WIDTH)) u_cnt_b (
    .clk(clk), .rst(rst), .en(w_en_b),   .out(w_cnt_b), .overflow(w_ovf_b)
  );
  counter #(.WIDTH(WIDTH)) u_cnt_c (
    .clk(clk), .rst(rst), .en(w_en_c),   .out(w_cnt_c), .overflow(w_ovf_c)
  );

  assign w_sa = (a > w_cnt_a);
  assign w_sb = (b > w_cnt_b);
  assign w_sc = (c > w_cnt_c);
  assign w_p  = w_sa & w_sb & w_sc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z  <= '0;
      r_ov <= 1'b0;
    end else if (w_en_int) begin
      if (w_p) begin
        r_z <= r_z + ZW'(1);
      end
      if (w_ovf_c) begin
        r_ov <= 1'b1;
      end
    end
  end

  assign z  = r_z;
  assign ov = r_ov;

endmodule

// File: tb/tb_dsc_mul.sv
// Scoreboard bench for dsc_mul: each run pushes its expected product and
// completion edge; a monitor compares them when ov rises.
module tb_dsc_mul;

  localparam int W   = 4;
  localparam int ZW  = 3 * W;
  localparam int NC  = 4096;

  typedef struct {
    logic [ZW-1:0] z;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [W-1:0]  a = '0, b = '0, c = '0;
  logic [ZW-1:0] z;
  logic          ov;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  logic prev_ov  = 1'b0;
  exp_t sb_q[$];

  dsc_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .z(z), .ov(ov)
  );

  always #5 clk = ~clk;

  // Posedges seen while out of reset; completion timing is measured against it.
  always @(posedge clk) if (rst) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising ov must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ov && !prev_ov) begin
      if (sb_q.size() == 0) begin
        check("ov_unexpected", 32'(ov), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_z", 32'(z), 32'(e.z));
        check("sb_ov_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_ov = ov;
  end

  task automatic apply_reset(input logic [W-1:0] na, input logic [W-1:0] nb,
                             input logic [W-1:0] nc);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("rst_z", 32'(z), 32'd0);
    check("rst_ov", 32'(ov), 32'd0);
    a = na; b = nb; c = nc;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits (bounded) for ov, then lets the monitor run and checks the frozen state.
  task automatic finish_run(input logic [ZW-1:0] exp_z);
    bit seen = 1'b0;
    for (int i = 0; i < NC + 300; i++) begin
      @(negedge clk);
      if (ov) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ov_timeout", 32'(ov), 32'd1);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    en = 1'b1;
    repeat (50) @(negedge clk);
    check("z_frozen", 32'(z), 32'(exp_z));
    check("ov_sticky", 32'(ov), 32'd1);
  endtask

  // One full operation; with pause_len>0, en drops after 1000 enabled edges.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic [W-1:0] rc, input logic [ZW-1:0] exp_z,
                        input int pause_len, input logic [ZW-1:0] exp_pause_z);
    exp_t e;
    apply_reset(ra, rb, rc);
    e.z   = exp_z;
    e.cyc = cyc + NC + pause_len;
    sb_q.push_back(e);
    en = 1'b1;
    @(negedge clk);
    check("z_k0", 32'(z), 32'((ra != 0) && (rb != 0) && (rc != 0)));
    if (pause_len > 0) begin
      repeat (999) @(negedge clk);
      en = 1'b0;
      repeat (pause_len) @(negedge clk);
      check("z_paused", 32'(z), 32'(exp_pause_z));
      check("ov_paused", 32'(ov), 32'd0);
      en = 1'b1;
    end
    finish_run(exp_z);
  endtask

  initial begin
    #1;
    check("init_z", 32'(z), 32'd0);
    check("init_ov", 32'(ov), 32'd0);

    run_op(4'd15, 4'd15, 4'd15, 12'd3375, 0, 12'd0);
    run_op(4'd5,  4'd3,  4'd7,  12'd105,  0, 12'd0);
    run_op(4'd0,  4'd15, 4'd15, 12'd0,    0, 12'd0);
    run_op(4'd1,  4'd1,  4'd1,  12'd1,    0, 12'd0);
    run_op(4'd9,  4'd10, 4'd11, 12'd990,  100, 12'd360);

    // Abort at k=2000: 7 full c-planes of 225 plus 13 b-rows of 15 = 1770.
    begin
      exp_t e;
      apply_reset(4'd15, 4'd15, 4'd15);
      en = 1'b1;
      repeat (2000) @(negedge clk);
      check("z_k2000", 32'(z), 32'd1770);
      apply_reset(4'd2, 4'd2, 4'd2);
      e.z   = 12'd8;
      e.cyc = cyc + NC;
      sb_q.push_back(e);
      en = 1'b1;
      finish_run(12'd8);
    end

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb, rc;
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rc = W'($urandom_range(0, 15));
      run_op(ra, rb, rc, ZW'(int'(ra) * int'(rb) * int'(rc)), 0, 12'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsc_mul.md
DSC_MUL -- requirements
Module: dsc_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit; high advances the operation one step per clock, low freezes all state.
REQ-005 SHALL have ports a, b, c, input, WIDTH bits each; unsigned operands, held stable by the user for the whole operation.
REQ-006 SHALL have port z, output, 3*WIDTH bits (12 at default); unsigned product accumulator.
REQ-007 SHALL have port ov, output, 1 bit; operation-finished flag.

Function
REQ-008 SHALL compute z = a*b*c exactly by deterministic unary (stochastic) multiplication; the width 3*WIDTH holds the maximum 15*15*15 = 3375 at WIDTH=4 without overflow.
REQ-009 SHALL keep three WIDTH-bit sequence counters, cnt_a, cnt_b and cnt_c. cnt_a advances on every enabled cycle. cnt_b advances when cnt_a wraps. cnt_c advances when cnt_b wraps.
REQ-010 With k = the number of enabled cycles since reset (0..2^(3*WIDTH)-1), SHALL hold cnt_a = k[WIDTH-1:0], cnt_b = k[2W-1:W] and cnt_c = k[3W-1:2W].
REQ-011 SHALL form the unary bits sa = (a > cnt_a), sb = (b > cnt_b) and sc = (c > cnt_c); these are combinational unsigned compares.
REQ-012 SHALL form the product bit p = sa & sb & sc.
REQ-013 On each enabled, not-finished cycle, z SHALL increment by 1 when p=1.
REQ-014 The operation SHALL take exactly 2^(3*WIDTH) enabled cycles (4096 at default).
REQ-015 ov SHALL be registered, and SHALL rise on the clock edge that completes the final enabled cycle (the edge on which cnt_c wraps). z SHALL hold the final product on that same edge.
REQ-016 After ov=1, the block SHALL ignore en: z and ov remain frozen and the counters do not advance until reset.
REQ-017 With en=0 mid-operation, all state SHALL hold. Resuming SHALL give the same final z, with ov delayed by the number of paused cycles.
REQ-018 If any operand is 0, z SHALL remain 0 and ov SHALL still assert after 2^(3*WIDTH) enabled cycles; there is no early termination.
REQ-019 Operand changes during an operation are outside the contract; z is then undefined but ov timing is unchanged.

Reset
REQ-020 rst=0 SHALL asynchronously clear cnt_a, cnt_b, cnt_c, z and ov to 0, regardless of clk and en.
REQ-021 Reset asserted mid-operation SHALL abort the operation. After release, the next operation starts from k=0 using the current operands.
REQ-022 The first enabled rising edge after reset release SHALL count as cycle k=0.

Structure
REQ-023 SHALL instantiate a sub-module named counter three times, for cnt_a, cnt_b and cnt_c.
REQ-024 counter SHALL have parameter WIDTH.
REQ-025 counter SHALL have ports clk, rst (async active-low), en, out [WIDTH-1:0] and overflow.
REQ-026 In counter, out SHALL increment by 1 (mod 2^WIDTH) on each enabled edge.
REQ-027 counter's overflow SHALL be combinational: overflow = en & (out == all ones).
REQ-028 The chaining SHALL be: en of the cnt_b counter = en_int & overflow_a; en of the cnt_c counter = en_int & overflow_b; en_int = en & ~ov. The completion event is overflow_c.
REQ-029 counter SHALL also be usable standalone (e.g. WIDTH=20 as a cycle counter).
REQ-030 A shared package SHALL hold the default WIDTH (4) and the derived constants OUT_W = 3*WIDTH and NUM_CYCLES = 2^(3*WIDTH).
REQ-031 The comparators and the AND gate SHALL stay inline in dsc_mul.

Verification
REQ-032 Bench: a=b=c=15, en=1 after reset -> z=3375; ov rises on the 4096th enabled edge and stays high.
REQ-033 Bench: a=5, b=3, c=7 -> z=105 and ov=1 after 4096 enabled cycles; z remains 105 for 50 further cycles with en still high.
REQ-034 Bench: a=0, b=15, c=15 -> z=0 throughout; ov=1 at cycle 4096.
REQ-035 Bench: a=b=c=1 -> z becomes 1 at k=0 and stays 1; final z=1.
REQ-036 Bench: a=9, b=10, c=11 with en low for 100 cycles starting at k=1000 -> z=990; ov asserts 4196 cycles after start.
REQ-037 Bench: rst pulled low at k=2000, then released with a=2, b=2, c=2 -> z=0 and ov=0 immediately; final z=8 after 4096 more enabled cycles.
REQ-038 Bench: 10 random operand triples, each with reset between runs -> every z equals a*b*c.
